// File: rtl/reg_file.sv
// reg_file: 32x32 register file with two registered read ports, write-back bypass and pending-write scoreboard
// Ports: clk/reset (sync, active-high); rd_valid, rs1_addr, rs2_addr, dst_en, dst_addr: operand-read request;
// rd_ready: combinational accept; out_valid, rs1_data, rs2_data: registered operands;
// wb_en, wb_addr, wb_data: write-back; busy: per-entry pending-write vector.
module reg_file #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_valid,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    input  logic             dst_en,
    input  logic [AW-1:0]    dst_addr,
    output logic             rd_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic [DEPTH-1:0] busy
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic             hit1, hit2, accept;
    logic [WIDTH-1:0] op1, op2;
    // Entry 0 is never written or claimed, so busy_q[0] and mem_q[0] stay zero.
    always_comb begin
        hit1     = wb_en && wb_addr == rs1_addr;
        hit2     = wb_en && wb_addr == rs2_addr;
        rd_ready = !((busy_q[rs1_addr] && !hit1) || (busy_q[rs2_addr] && !hit2));
        accept   = rd_valid && rd_ready;
        op1      = rs1_addr == '0 ? '0 : hit1 ? wb_data : mem_q[rs1_addr];
        op2      = rs2_addr == '0 ? '0 : hit2 ? wb_data : mem_q[rs2_addr];
        mem_d    = mem_q;
        if (wb_en && wb_addr != '0) mem_d[wb_addr] = wb_data;
        // A new claim supersedes a same-cycle write-back clear of that entry.
        busy_d = busy_q;
        if (wb_en) busy_d[wb_addr] = 1'b0;
        if (accept && dst_en && dst_addr != '0) busy_d[dst_addr] = 1'b1;
        out_valid_d = accept;
        rs1_d       = accept ? op1 : rs1_q;
        rs2_d       = accept ? op2 : rs2_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
        end else begin
            mem_q       <= mem_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
        end
    end
    assign out_valid = out_valid_q;
    assign rs1_data  = rs1_q;
    assign rs2_data  = rs2_q;
    assign busy      = busy_q;
endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the datapath: 32 entries of 32 bits with two registered read ports, one write-back port and a per-entry pending-write scoreboard. It sits between decode and execute and serves the read side of the per-register storage. Decode issues operand reads; the block stalls a read whose source has an outstanding write, and forwards same-cycle write-back data. Entry 0 reads as constant zero.

## Interface
- WIDTH, 32, data width of each entry
- DEPTH, 32, number of entries (entry 0 hardwired to zero)
- AW, 5, address width, equal to log2(DEPTH)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rd_valid  in  1  decode presents an operand-read request
- rs1_addr  in  AW  source 1 address
- rs2_addr  in  AW  source 2 address
- dst_en  in  1  request will produce a result (claims dst_addr)
- dst_addr  in  AW  destination to mark pending on acceptance
- rd_ready  out  1  combinational: request accepted this cycle if rd_valid=1
- out_valid  out  1  registered: rs1_data/rs2_data valid this cycle
- rs1_data  out  WIDTH  registered source 1 operand
- rs2_data  out  WIDTH  registered source 2 operand
- wb_en  in  1  write-back strobe
- wb_addr  in  AW  write-back address
- wb_data  in  WIDTH  write-back data
- busy  out  DEPTH  scoreboard vector, bit n set = entry n has a pending write

## Operation
- Storage: mem[1..DEPTH-1]; mem[0] does not exist, reads return 0.
- Write: wb_en=1 and wb_addr!=0 -> mem[wb_addr] <= wb_data at the edge. wb_addr=0 ignored. A write to a non-busy entry is legal and simply updates it.
- Hazard: hz1 = busy[rs1_addr] and not (wb_en and wb_addr==rs1_addr); hz2 likewise for rs2. busy[0] is constant 0.
- rd_ready = not (hz1 or hz2); independent of rd_valid; no internal backpressure otherwise.
- Accept = rd_valid and rd_ready. On accept: rs1_data <= operand 1, rs2_data <= operand 2, out_valid <= 1. Otherwise out_valid <= 0 and rs*_data hold their last value.
- Operand selection, per port: address 0 -> 0; else wb_en and wb_addr==addr -> wb_data (bypass); else mem[addr].
- Scoreboard update per edge: clear busy[wb_addr] if wb_en; then set busy[dst_addr] if accept and dst_en and dst_addr!=0. Set wins over clear on the same entry (new producer supersedes).
- A request whose dst_addr equals one of its own sources reads the old value (claim takes effect after the read).
- No state machine beyond scoreboard; block is fully pipelined, one accept per cycle max.

## Timing
- Reset (sync, edge with reset=1): all mem entries 0, busy=0, out_valid=0, rs1_data=rs2_data=0. Reset overrides any same-cycle write, read or claim.
- Read latency: 1 cycle from accept to out_valid=1 with data.
- Write-to-read: write-back in cycle N is visible to a read accepted in cycle N via bypass, and via storage in N+1 onward.
- Stall release: a request stalled on busy[r] is accepted in the same cycle the matching write-back arrives, with bypassed data.
- rd_ready is purely combinational from addresses, busy and wb_*; no combinational path from rd_valid to rd_ready.

## Test plan
- Reset then read rs1=3, rs2=0 -> next cycle out_valid=1, rs1_data=0, rs2_data=0, busy=0.
- wb_en, addr 5, data 0xDEADBEEF in cycle N with read rs1=5 in N -> rd_ready=1, rs1_data=0xDEADBEEF at N+1; re-read at N+2 returns same.
- Accept with dst_en, dst_addr=7; next request rs2=7 -> rd_ready=0, out_valid=0 for every stall cycle; write-back 7=0x12345678 arrives -> accepted that cycle, rs2_data=0x12345678 next cycle, busy[7]=0.
- Same cycle: wb to entry 9 clears and accepted request claims dst 9 -> busy[9]=1 afterwards.
- wb_en to addr 0 with data 0xFFFFFFFF, dst_en with dst_addr 0 -> reads of 0 return 0, busy[0] stays 0, never stalls.
- Assert reset while busy[4]=1 and a write is in flight -> busy=0, out_valid=0, mem[4]=0 after the edge; first post-reset read of 4 accepted immediately returning 0.
